// File: rtl/spike_wb_packer_pkg.sv
// Shared widths, defaults and FSM encoding for the spike write-back packer.
// Any define already set by the shared hyper_para header takes precedence.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef TIME_STEPS
`define TIME_STEPS 4
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef LEN_WIDTH
`define LEN_WIDTH 8
`endif
`ifndef SPK_WB_BASE_ADDR
`define SPK_WB_BASE_ADDR 0
`endif
`ifndef SPK_WB_BURST_LEN
`define SPK_WB_BURST_LEN 16
`endif

package spike_wb_packer_pkg;

    localparam int SPK_DATA_WIDTH = `DATA_WIDTH;
    localparam int SPK_TIME_STEPS = `TIME_STEPS;
    localparam int SPK_ADDR_SIZE  = `ADDR_SIZE;
    localparam int SPK_LEN_WIDTH  = `LEN_WIDTH;
    localparam int SPK_BASE_ADDR  = `SPK_WB_BASE_ADDR;
    localparam int SPK_BURST_LEN  = `SPK_WB_BURST_LEN;
    localparam int SPK_FIFO_DEPTH = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_LAST,
        ST_DONE
    } wb_state_t;

endpackage

// File: rtl/spike_wb_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module spike_wb_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW + 1)'(DEPTH));
    assign rd_ok   = rd_en && !empty;
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign rd_data = mem[rd_ptr];

    // NOTE: storage has no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spike_wb_packer.sv
// Packs encoder spike vectors into words, buffers them, and writes them out as
// fixed-length bursts; on encoder completion flushes the partial word/burst.
module spike_wb_packer
    import spike_wb_packer_pkg::*;
#(
    parameter int          DATA_WIDTH = SPK_DATA_WIDTH,
    parameter int          TIME_STEPS = SPK_TIME_STEPS,
    parameter int          ADDR_SIZE  = SPK_ADDR_SIZE,
    parameter int          LEN_WIDTH  = SPK_LEN_WIDTH,
    parameter int unsigned BASE_ADDR  = SPK_BASE_ADDR,
    parameter int          BURST_LEN  = SPK_BURST_LEN,
    parameter int          FIFO_DEPTH = SPK_FIFO_DEPTH
) (
    input  logic                  s_clk,
    input  logic                  s_rst,
    input  logic [TIME_STEPS-1:0] i_spike,
    input  logic                  i_spike_valid,
    input  logic                  i_encoder_done,
    output logic [DATA_WIDTH-1:0] wr_burst_data,
    output logic [ADDR_SIZE-1:0]  wr_burst_addr,
    output logic [LEN_WIDTH-1:0]  wr_burst_len,
    output logic                  wr_burst_req,
    input  logic                  wr_burst_data_req,
    input  logic                  wr_burst_finish,
    output logic                  o_wb_done,
    output logic                  o_overflow,
    output logic                  o_busy
);

    localparam int VPW   = DATA_WIDTH / TIME_STEPS;
    localparam int CNT_W = (VPW > 1) ? $clog2(VPW) : 1;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] pack_word;
    logic [DATA_WIDTH-1:0] pack_next;
    logic [DATA_WIDTH-1:0] push_data;
    logic [DATA_WIDTH-1:0] head;
    logic [CNT_W-1:0]      pack_cnt;
    logic [CW-1:0]         count;
    logic                  push_full;
    logic                  pad_push;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic                  flush_pending;
    logic                  last_burst;
    wb_state_t             state;

    // NOTE: default-assign before the partial update so no latch is inferred.
    always_comb begin
        pack_next = pack_word;
        pack_next[pack_cnt*TIME_STEPS +: TIME_STEPS] = i_spike;
    end

    // The partial word is padded only once no new vector competes for the slot.
    assign push_full     = i_spike_valid && (pack_cnt == CNT_W'(VPW - 1));
    assign pad_push      = flush_pending && (pack_cnt != '0) && !i_spike_valid;
    assign push          = push_full || pad_push;
    assign push_data     = push_full ? pack_next : pack_word;
    assign pop           = wr_burst_data_req && !empty;
    assign wr_burst_data = empty ? '0 : head;

    spike_wb_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (s_clk),
        .rst     (s_rst),
        .wr_en   (push),
        .wr_data (push_data),
        .rd_en   (wr_burst_data_req),
        .rd_data (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            pack_word <= '0;
            pack_cnt  <= '0;
        end else if (i_spike_valid) begin
            if (push_full) begin
                pack_word <= '0;
                pack_cnt  <= '0;
            end else begin
                pack_word <= pack_next;
                pack_cnt  <= pack_cnt + 1'b1;
            end
        end else if (pad_push) begin
            pack_word <= '0;
            pack_cnt  <= '0;
        end
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            state         <= ST_IDLE;
            wr_burst_req  <= 1'b0;
            wr_burst_addr <= ADDR_SIZE'(BASE_ADDR);
            wr_burst_len  <= '0;
            o_wb_done     <= 1'b0;
            o_overflow    <= 1'b0;
            o_busy        <= 1'b0;
            flush_pending <= 1'b0;
            last_burst    <= 1'b0;
        end else begin
            if (i_encoder_done) flush_pending <= 1'b1;
            if (i_spike_valid)  o_busy        <= 1'b1;
            if (push && full && !pop) o_overflow <= 1'b1;

            case (state)
                ST_IDLE: begin
                    // Full bursts drain first; the flush burst only takes what is left.
                    if (count >= CW'(BURST_LEN)) begin
                        state        <= ST_REQ;
                        wr_burst_req <= 1'b1;
                        wr_burst_len <= LEN_WIDTH'(BURST_LEN);
                        last_burst   <= 1'b0;
                    end else if (flush_pending && (pack_cnt == '0) && !push) begin
                        flush_pending <= 1'b0;
                        if (count == '0) begin
                            state     <= ST_DONE;
                            o_wb_done <= 1'b1;
                        end else begin
                            state        <= ST_LAST;
                            wr_burst_req <= 1'b1;
                            wr_burst_len <= LEN_WIDTH'(count);
                            last_burst   <= 1'b1;
                        end
                    end
                end
                ST_REQ, ST_LAST: begin
                    if (wr_burst_data_req) begin
                        state        <= ST_XFER;
                        wr_burst_req <= 1'b0;
                    end
                end
                ST_XFER: begin
                    if (wr_burst_finish) begin
                        if (last_burst) begin
                            state     <= ST_DONE;
                            o_wb_done <= 1'b1;
                        end else begin
                            state         <= ST_IDLE;
                            wr_burst_addr <= wr_burst_addr
                                + ADDR_SIZE'(wr_burst_len) * ADDR_SIZE'(DATA_WIDTH / 8);
                        end
                    end
                end
                ST_DONE: begin
                    state         <= ST_IDLE;
                    o_wb_done     <= 1'b0;
                    o_busy        <= i_spike_valid;
                    wr_burst_addr <= ADDR_SIZE'(BASE_ADDR);
                    last_burst    <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spike_wb_packer.sv
// Randomised scoreboard bench for spike_wb_packer: stimulus pushes expected
// words/bursts from a frame-level model; an arbiter/monitor process checks them.
module tb_spike_wb_packer;

    localparam int DEPTH = 64;
    localparam int BL    = 16;
    localparam int VPW   = 16;

    typedef struct {
        logic [31:0] addr;
        int          len;
    } burst_t;

    logic        s_clk = 1'b0;
    logic        s_rst;
    logic [3:0]  i_spike;
    logic        i_spike_valid;
    logic        i_encoder_done;
    logic [63:0] wr_burst_data;
    logic [31:0] wr_burst_addr;
    logic [7:0]  wr_burst_len;
    logic        wr_burst_req;
    logic        wr_burst_data_req;
    logic        wr_burst_finish;
    logic        o_wb_done;
    logic        o_overflow;
    logic        o_busy;

    spike_wb_packer dut (
        .s_clk             (s_clk),
        .s_rst             (s_rst),
        .i_spike           (i_spike),
        .i_spike_valid     (i_spike_valid),
        .i_encoder_done    (i_encoder_done),
        .wr_burst_data     (wr_burst_data),
        .wr_burst_addr     (wr_burst_addr),
        .wr_burst_len      (wr_burst_len),
        .wr_burst_req      (wr_burst_req),
        .wr_burst_data_req (wr_burst_data_req),
        .wr_burst_finish   (wr_burst_finish),
        .o_wb_done         (o_wb_done),
        .o_overflow        (o_overflow),
        .o_busy            (o_busy)
    );

    always #5 s_clk = ~s_clk;

    logic [63:0] exp_words [$];
    burst_t      exp_bursts [$];
    int          n_vectors = 0;
    int          n_miscompares = 0;
    logic [63:0] cur_word = '0;
    int          nvec = 0;
    int          stored = 0;
    logic        exp_overflow = 1'b0;
    int          exp_done = 0;
    int          done_seen = 0;
    int          bursts_seen = 0;
    int          words_done = 0;
    bit          arb_en = 1'b1;
    bit          in_burst = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Frame model: words fill vector by vector; every BL stored words form a burst.
    task automatic store_word(input logic [63:0] w);
        burst_t b;
        if (exp_words.size() >= DEPTH) begin
            exp_overflow = 1'b1;
        end else begin
            exp_words.push_back(w);
            stored++;
            if (stored % BL == 0) begin
                b.addr = 32'((stored / BL - 1) * BL * 8);
                b.len  = BL;
                exp_bursts.push_back(b);
            end
        end
    endtask

    task automatic finish_frame();
        burst_t b;
        if (nvec > 0) store_word(cur_word);
        if (stored % BL != 0) begin
            b.addr = 32'((stored / BL) * BL * 8);
            b.len  = stored % BL;
            exp_bursts.push_back(b);
        end
        exp_done++;
        cur_word = '0;
        nvec     = 0;
        stored   = 0;
    endtask

    task automatic send_vec(input logic [3:0] v, input bit d);
        i_spike        = v;
        i_spike_valid  = 1'b1;
        i_encoder_done = d;
        cur_word = cur_word | (64'(v) << (4 * nvec));
        nvec++;
        if (nvec == VPW) begin
            store_word(cur_word);
            cur_word = '0;
            nvec     = 0;
        end
        if (d) finish_frame();
        @(negedge s_clk);
        i_spike_valid  = 1'b0;
        i_encoder_done = 1'b0;
    endtask

    task automatic send_done();
        i_encoder_done = 1'b1;
        finish_frame();
        @(negedge s_clk);
        i_encoder_done = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int k = 0;
        while ((exp_bursts.size() != 0 || exp_words.size() != 0 || in_burst) && k < budget) begin
            @(negedge s_clk);
            k++;
        end
        check(name, 64'(exp_bursts.size() + exp_words.size()), 64'd0);
    endtask

    task automatic wait_done(input int budget, input string name);
        int k = 0;
        while (done_seen < exp_done && k < budget) begin
            @(negedge s_clk);
            k++;
        end
        check(name, 64'(done_seen), 64'(exp_done));
        check({name, "_drained"}, 64'(exp_bursts.size() + exp_words.size()), 64'd0);
    endtask

    initial begin
        forever begin
            @(negedge s_clk);
            if (o_wb_done === 1'b1) done_seen++;
        end
    end

    // Arbiter model and data monitor.
    initial begin
        burst_t      eb;
        int          blen;
        logic [31:0] baddr;
        wr_burst_data_req = 1'b0;
        wr_burst_finish   = 1'b0;
        forever begin
            @(negedge s_clk);
            if (!s_rst && arb_en && wr_burst_req === 1'b1) begin
                in_burst   = 1'b1;
                words_done = 0;
                repeat ($urandom_range(0, 2)) @(negedge s_clk);
                blen  = int'(wr_burst_len);
                baddr = wr_burst_addr;
                bursts_seen++;
                if (exp_bursts.size() == 0) begin
                    n_vectors++;
                    n_miscompares++;
                    $display("FAIL unexpected_burst: got addr %h len %0d expected none", baddr, blen);
                end else begin
                    eb = exp_bursts.pop_front();
                    check("burst_addr", 64'(baddr), 64'(eb.addr));
                    check("burst_len", 64'(blen), 64'(eb.len));
                end
                for (int i = 0; i < blen; i++) begin
                    if (s_rst) break;
                    if (exp_words.size() == 0) begin
                        n_vectors++;
                        n_miscompares++;
                        $display("FAIL burst_word: got %h expected no word", wr_burst_data);
                    end else begin
                        check("burst_word", wr_burst_data, exp_words.pop_front());
                    end
                    wr_burst_data_req = 1'b1;
                    words_done++;
                    @(negedge s_clk);
                end
                wr_burst_data_req = 1'b0;
                if (!s_rst) begin
                    wr_burst_finish = 1'b1;
                    @(negedge s_clk);
                    wr_burst_finish = 1'b0;
                end
                in_burst = 1'b0;
            end
        end
    end

    initial begin
        int  b0;
        int  n;
        int  k;
        bit  coincide;
        s_rst          = 1'b1;
        i_spike        = '0;
        i_spike_valid  = 1'b0;
        i_encoder_done = 1'b0;
        repeat (3) @(negedge s_clk);
        check("rst_req", 64'(wr_burst_req), 64'd0);
        check("rst_addr", 64'(wr_burst_addr), 64'd0);
        check("rst_len", 64'(wr_burst_len), 64'd0);
        check("rst_data", wr_burst_data, 64'd0);
        check("rst_done", 64'(o_wb_done), 64'd0);
        check("rst_overflow", 64'(o_overflow), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        s_rst = 1'b0;
        @(negedge s_clk);

        // One full burst of 0xA patterns, no completion yet; then a second burst and done.
        b0 = bursts_seen;
        for (int i = 0; i < 256; i++) send_vec(4'b1010, 1'b0);
        wait_drain(300, "t1_drain");
        check("t1_no_done", 64'(done_seen), 64'd0);
        check("t1_busy", 64'(o_busy), 64'd1);
        for (int i = 0; i < 256; i++) send_vec(4'($urandom), 1'b0);
        wait_drain(300, "t2_drain");
        send_done();
        repeat (2) @(negedge s_clk);
        check("t2_done_fast", 64'(done_seen), 64'(exp_done));
        check("t2_bursts", 64'(bursts_seen - b0), 64'd2);
        @(negedge s_clk);
        check("t2_busy_clear", 64'(o_busy), 64'd0);

        // Partial frame: 20 all-ones vectors give a padded second word.
        for (int i = 0; i < 20; i++) send_vec(4'b1111, 1'b0);
        send_done();
        wait_done(200, "t3_done");

        // Done coincident with the 16th vector: single-word flush burst.
        for (int i = 0; i < 15; i++) send_vec(4'($urandom), 1'b0);
        send_vec(4'($urandom), 1'b1);
        wait_done(200, "t4_done");

        // Random frames with gaps and either done placement.
        for (int f = 0; f < 4; f++) begin
            n        = int'($urandom_range(1, 600));
            coincide = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge s_clk);
                send_vec(4'($urandom), coincide && (i == n - 1));
            end
            if (!coincide) begin
                repeat ($urandom_range(0, 3)) @(negedge s_clk);
                send_done();
            end
            wait_done(3000, "rand_done");
        end

        // Overflow: grants withheld while 65 words arrive.
        arb_en = 1'b0;
        b0     = bursts_seen;
        for (int i = 0; i < 1040; i++) send_vec(4'($urandom), 1'b0);
        repeat (3) @(negedge s_clk);
        check("ovf_flag", 64'(o_overflow), 64'(exp_overflow));
        check("ovf_req_waiting", 64'(wr_burst_req), 64'd1);
        check("ovf_req_addr", 64'(wr_burst_addr), 64'd0);
        arb_en = 1'b1;
        wait_drain(1000, "ovf_drain");
        check("ovf_bursts", 64'(bursts_seen - b0), 64'd4);
        send_done();
        wait_done(200, "ovf_done");
        check("ovf_sticky", 64'(o_overflow), 64'd1);

        // Reset in the middle of a transfer.
        for (int i = 0; i < 256; i++) send_vec(4'($urandom), 1'b0);
        k = 0;
        while (!(in_burst && words_done >= 5) && k < 200) begin
            @(posedge s_clk);
            k++;
        end
        check("rst_reach_xfer", 64'(words_done >= 5), 64'd1);
        #2 s_rst = 1'b1;
        #1;
        check("mid_rst_req", 64'(wr_burst_req), 64'd0);
        check("mid_rst_addr", 64'(wr_burst_addr), 64'd0);
        check("mid_rst_len", 64'(wr_burst_len), 64'd0);
        check("mid_rst_data", wr_burst_data, 64'd0);
        check("mid_rst_overflow", 64'(o_overflow), 64'd0);
        check("mid_rst_busy", 64'(o_busy), 64'd0);
        repeat (3) @(negedge s_clk);
        exp_words.delete();
        exp_bursts.delete();
        cur_word     = '0;
        nvec         = 0;
        stored       = 0;
        exp_overflow = 1'b0;
        s_rst        = 1'b0;
        @(negedge s_clk);
        for (int i = 0; i < 256; i++) send_vec(4'($urandom), 1'b0);
        send_done();
        wait_done(400, "post_rst_done");
        check("post_rst_overflow", 64'(o_overflow), 64'(exp_overflow));

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/spike_wb_packer.md
Name: spike_wb_packer

Overview:
- Downstream of the spiking encoder; consumes its TIME_STEPS-wide spike vectors (one per output neuron) and packs them into DATA_WIDTH words.
- Buffers packed words in an internal FIFO and writes them to DDR through one write channel (wNN_burst_*) of round_robin_arb, as bursts of fixed length.
- On encoder completion, flushes the partial word and the partial burst, then reports done.

Parameters:
- DATA_WIDTH, `DATA_WIDTH (64): packed word and burst data width.
- TIME_STEPS, `TIME_STEPS (4): spike vector width.
- ADDR_SIZE, `ADDR_SIZE: burst byte-address width.
- LEN_WIDTH, `LEN_WIDTH: burst length width.
- BASE_ADDR, 0: byte address of the first burst.
- BURST_LEN, 16: words per full burst; must be ≤ FIFO_DEPTH.
- FIFO_DEPTH, 64: packed-word FIFO depth; power of 2.

Ports:
- s_clk  in  1  clock.
- s_rst  in  1  reset; asynchronous, active-high.
- i_spike  in  TIME_STEPS  spike vector; bit t = time step t.
- i_spike_valid  in  1  i_spike qualifier; no backpressure.
- i_encoder_done  in  1  one-cycle pulse: last vector already delivered or delivered this cycle.
- wr_burst_data  out  DATA_WIDTH  write data (FIFO head).
- wr_burst_addr  out  ADDR_SIZE  burst start byte address.
- wr_burst_len  out  LEN_WIDTH  burst length in words.
- wr_burst_req  out  1  burst request.
- wr_burst_data_req  in  1  arbiter consumes wr_burst_data this cycle.
- wr_burst_finish  in  1  burst complete pulse.
- o_wb_done  out  1  one-cycle pulse: all data written.
- o_overflow  out  1  sticky; a packed word was dropped.
- o_busy  out  1  high from the first accepted vector until o_wb_done.

Behaviour:
- Reset: all outputs 0, wr_burst_addr = BASE_ADDR, FIFO empty, pack counter 0, FSM IDLE. Reset mid-burst aborts the burst immediately; nothing is resumed.
- Packing:
  - Vector k of a word occupies bits [k*TIME_STEPS +: TIME_STEPS]; k = 0 is LSB.
  - Vectors per word VPW = DATA_WIDTH/TIME_STEPS (16 at default).
  - When the VPW-th vector is accepted, the word is pushed to the FIFO in the next cycle.
- FIFO:
  - FWFT; wr_burst_data = head word, combinational.
  - Pop on wr_burst_data_req.
  - A push that arrives while the FIFO is full is dropped and sets o_overflow. o_overflow clears only on reset.
  - Simultaneous push and pop when full is allowed; the push is not dropped.
- FSM IDLE → REQ → XFER → IDLE; FLUSH, LAST and DONE handle end of frame.
  - IDLE → REQ: FIFO count ≥ BURST_LEN. Latch len = BURST_LEN.
  - REQ: wr_burst_req = 1 and wr_burst_addr/len held stable. Leave to XFER on the first wr_burst_data_req, and drop req in the same cycle.
  - XFER: pop once per data_req.
    - On wr_burst_finish: wr_burst_addr += len*DATA_WIDTH/8, then go to IDLE (or to LAST if a flush is pending).
    - A data_req arriving while the FIFO is empty is an arbiter protocol error. Drive wr_burst_data = 0 and do not pop.
  - Flush:
    - i_encoder_done sets flush_pending; a vector valid in the same cycle is packed first.
    - If the pack counter is nonzero, the partial word is zero-padded in its upper bits and pushed.
    - Then, once no burst is active, go to LAST with len = FIFO count. If the count is 0, go straight to DONE.
  - LAST: same handshake as REQ/XFER. On finish, go to DONE.
  - DONE: pulse o_wb_done, reset wr_burst_addr to BASE_ADDR, clear o_busy, return to IDLE.
- i_spike_valid during DONE is accepted and starts a new frame.
- Latency: a full word is FIFO-visible 1 cycle after its last vector. wr_burst_req rises 1 cycle after the count threshold is met.

Decomposition:
- Widths come from the shared hyper_para defines. Add BASE_ADDR and BURST_LEN there as `SPK_WB_BASE_ADDR and `SPK_WB_BURST_LEN.
- Natural sub-module: spike_wb_fifo, a synchronous FWFT FIFO with count, full and empty outputs.
- Packing and the FSM stay in spike_wb_packer.

Test Plan:
- 256 continuous vectors of pattern 4'b1010; arbiter grants data_req continuously → one burst at addr 0, len 16, every word 64'hAAAA_AAAA_AAAA_AAAA. No o_wb_done yet.
- 512 vectors → 2 bursts, at addr 0x000 and 0x080. Then i_encoder_done → o_wb_done within 2 cycles, with no extra burst.
- 20 vectors 4'b1111, then done → a single LAST burst at addr 0, len 2: word0 = all ones, word1 = 64'h0000_0000_0000_FFFF. Then o_wb_done.
- data_req held low while 1040 vectors are fed (65 words) → o_overflow = 1 and FIFO holds 64 words. Releasing data_req drains 4 bursts of 16 words.
- i_encoder_done coincident with the 16th vector → that vector is included. Burst len 1 is issued, with no padded extra word.
- s_rst asserted mid-XFER → all outputs 0 immediately and wr_burst_addr = BASE_ADDR. A fresh 256-vector frame after reset writes correctly at addr 0.
